fetch_redirect_ctrl: RTL

//  Front-end consumer of the branch/jump decision (i_B_J_result): owns the PC, issues
//  in-order instruction-memory requests, buffers returned words, and delivers them to

---
 rtl/soin_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_redirect_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/soin_pkg.sv
// Shared types and constants for the fetch front-end.
package soin_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;

  // One buffered fetch: the returned word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // RUN: every response is live. DRAIN: stale responses still to be dropped.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
module fetch_fifo
  import soin_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointers, occupancy and storage; flush discards everything including a same-cycle push.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (i_push) begin
        mem_d[wr_q] = i_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (i_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(i_push) - CW'(i_pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_head  = mem_q[rd_q];
  assign o_valid = (cnt_q != '0);
  assign o_count = cnt_q;

  a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && !i_flush && cnt_q == CW'(DEPTH)));
  a_fifo_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_pop && cnt_q == '0));

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: issues in-order IMEM requests, buffers responses for decode,
// and on a taken branch/jump redirects, flushes and drops every stale response.
module fetch_redirect_ctrl
  import soin_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_B_J_result,
  input  logic [XLEN-1:0] i_target,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [CW-1:0]   out_q, out_d;      // granted, response not yet returned
  logic [CW-1:0]   disc_q, disc_d;    // responses still to be dropped
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;    // address currently (or next) presented
  logic [XLEN-1:0] nxt_q, nxt_d;      // redirect target parked behind a stale pending request
  logic            stale_q, stale_d;  // presented request predates a redirect
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;

  logic            gnt_fire, drop, push, pop;
  logic [CW:0]     cnt_nxt;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_valid;
  fetch_entry_t    fifo_head, fifo_in;

  assign gnt_fire = req_q & i_imem_gnt;
  assign drop     = (state_q == ST_DRAIN);
  assign push     = i_imem_rvalid & ~drop & ~i_B_J_result;
  assign pop      = fifo_valid & i_instr_ready & ~i_B_J_result;
  assign fifo_in  = '{instr: i_imem_rdata, pc: rsp_pc_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (fifo_in),
    .i_pop   (pop),
    .i_flush (i_B_J_result),
    .o_head  (fifo_head),
    .o_valid (fifo_valid),
    .o_count (fifo_cnt)
  );

  // Credit accounting, request generation, discard count and PC tracking.
  always_comb begin
    out_d    = out_q + CW'(gnt_fire) - CW'(i_imem_rvalid);
    cnt_nxt  = i_B_J_result ? '0 : ({1'b0, fifo_cnt} + (CW + 1)'(push) - (CW + 1)'(pop));
    // Credits never grow without a grant, so a raised request stays raised until granted.
    req_d    = (({1'b0, out_d}) + cnt_nxt) < DEPTH_W;

    if (i_B_J_result) disc_d = out_d;
    else              disc_d = disc_q - CW'(i_imem_rvalid & drop) + CW'(gnt_fire & stale_q);

    addr_d   = addr_q;
    nxt_d    = nxt_q;
    stale_d  = stale_q;
    if (gnt_fire) begin
      addr_d  = stale_q ? nxt_q : addr_q + 32'd4;
      stale_d = 1'b0;
    end
    if (i_B_J_result) begin
      // A request already on the bus must not change; park the target behind it.
      if (req_q && !i_imem_gnt) begin
        nxt_d   = word_align(i_target);
        stale_d = 1'b1;
      end else begin
        addr_d  = word_align(i_target);
      end
    end

    rsp_pc_d = rsp_pc_q;
    if (i_B_J_result) rsp_pc_d = word_align(i_target);
    else if (push)    rsp_pc_d = rsp_pc_q + 32'd4;
  end

  // RUN/DRAIN next state: DRAIN while any stale response is still expected.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (disc_d != '0) state_d = ST_DRAIN;
      ST_DRAIN: if (disc_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      out_q    <= '0;
      disc_q   <= '0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      nxt_q    <= RESET_PC;
      stale_q  <= 1'b0;
      rsp_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      nxt_q    <= nxt_d;
      stale_q  <= stale_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = addr_q;
  assign o_instr_valid = fifo_valid;
  assign o_instr       = fifo_valid ? fifo_head.instr : '0;
  assign o_instr_pc    = fifo_valid ? fifo_head.pc    : '0;

  a_out_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(gnt_fire && !i_imem_rvalid && out_q == CW'(DEPTH)));
  a_out_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rvalid && out_q == '0));
  a_disc_bounded: assert property (@(posedge i_clk) disable iff (i_rst)
    disc_q <= out_q);
  a_state_matches: assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == ST_DRAIN) == (disc_q != '0));

endmodule
